// File: rtl/sm3_arb_pkg.sv
// sm3_arb_pkg: shared types, default sizes and helpers for the SM3 core arbiter.
// Rev 1.0
`default_nettype none

package sm3_arb_pkg;

  localparam int N_REQ_DEF  = 4;
  localparam int DATA_W_DEF = 32;
  localparam int RES_W_DEF  = 256;
  localparam int MAX_REQ    = 8;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    XFER     = 2'd1,
    WAIT_RES = 2'd2
  } state_t;

  // Sized for the largest supported channel count; callers truncate to N_REQ.
  function automatic logic [MAX_REQ-1:0] onehot(input logic [2:0] idx);
    onehot      = '0;
    onehot[idx] = 1'b1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sm3_rr_pick.sv
// sm3_rr_pick: combinational round-robin picker, first request at or after rr_ptr.
// Rev 1.0
`default_nettype none

module sm3_rr_pick #(
  parameter int N_REQ = 4,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] rr_ptr,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  logic [2*N_REQ-1:0] dbl;
  logic [2*N_REQ-1:0] mask;
  logic [2*N_REQ-1:0] masked;

  // Upper copy stays unmasked so the search wraps past the top channel.
  assign dbl    = {req, req};
  assign mask   = {(2*N_REQ){1'b1}} << rr_ptr;
  assign masked = dbl & mask;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int i = 2*N_REQ-1; i >= 0; i--) begin
      if (masked[i]) begin
        found = 1'b1;
        idx   = IDX_W'(i % N_REQ);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/sm3_core_arb.sv
// sm3_core_arb: message-locked round-robin arbiter sharing one SM3 core among N_REQ channels.
// Rev 1.0
`default_nettype none

module sm3_core_arb
  import sm3_arb_pkg::*;
#(
  parameter int N_REQ  = N_REQ_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int RES_W  = RES_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ*DATA_W-1:0] req_data_i,
  input  logic [N_REQ-1:0]        req_vld_i,
  input  logic [N_REQ-1:0]        req_lst_i,
  output logic [N_REQ-1:0]        req_rdy_o,
  output logic [DATA_W-1:0]       core_inpt_data_o,
  output logic                    core_inpt_vld_o,
  output logic                    core_inpt_lst_o,
  input  logic                    core_inpt_rdy_i,
  input  logic [RES_W-1:0]        core_otpt_res_i,
  input  logic                    core_otpt_vld_i,
  output logic [RES_W-1:0]        res_data_o,
  output logic [N_REQ-1:0]        res_vld_o,
  output logic [N_REQ-1:0]        gnt_o,
  output logic                    err_unexp_o
);

  localparam int IDX_W = $clog2(N_REQ);

  state_t             state, state_nxt;
  logic [IDX_W-1:0]   gnt_idx;
  logic [IDX_W-1:0]   rr_ptr;
  logic               pick_found;
  logic [IDX_W-1:0]   pick_idx;
  logic [N_REQ-1:0]   gnt_oh;
  logic [DATA_W-1:0]  req_word [N_REQ];

  for (genvar k = 0; k < N_REQ; k++) begin : g_unpack
    assign req_word[k] = req_data_i[k*DATA_W +: DATA_W];
  end

  sm3_rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req    (req_vld_i),
    .rr_ptr (rr_ptr),
    .found  (pick_found),
    .idx    (pick_idx)
  );

  assign gnt_oh = N_REQ'(onehot(3'(gnt_idx)));

  always_comb begin
    state_nxt        = state;
    core_inpt_data_o = req_word[gnt_idx];
    core_inpt_vld_o  = 1'b0;
    core_inpt_lst_o  = 1'b0;
    req_rdy_o        = '0;
    gnt_o            = '0;
    unique case (state)
      IDLE: begin
        if (pick_found) state_nxt = XFER;
      end
      XFER: begin
        gnt_o           = gnt_oh;
        core_inpt_vld_o = req_vld_i[gnt_idx];
        core_inpt_lst_o = req_lst_i[gnt_idx];
        req_rdy_o       = core_inpt_rdy_i ? gnt_oh : '0;
        if (req_vld_i[gnt_idx] && core_inpt_rdy_i && req_lst_i[gnt_idx])
          state_nxt = WAIT_RES;
      end
      WAIT_RES: begin
        gnt_o = gnt_oh;
        if (core_otpt_vld_i) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      gnt_idx     <= '0;
      rr_ptr      <= '0;
      res_data_o  <= '0;
      res_vld_o   <= '0;
      err_unexp_o <= 1'b0;
    end else begin
      state       <= state_nxt;
      res_vld_o   <= '0;
      err_unexp_o <= 1'b0;
      if (state == IDLE && pick_found) gnt_idx <= pick_idx;
      // Only the owner's digest is forwarded; anything else is dropped and flagged.
      if (core_otpt_vld_i) begin
        if (state == WAIT_RES) begin
          res_data_o <= core_otpt_res_i;
          res_vld_o  <= gnt_oh;
          rr_ptr     <= (gnt_idx == IDX_W'(N_REQ-1)) ? '0 : gnt_idx + 1'b1;
          gnt_idx    <= '0;
        end else begin
          err_unexp_o <= 1'b1;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: doc/sm3_core_arb.md
Name: sm3_core_arb

Overview:
- Round-robin arbiter that shares one SM3 hash core (padding, expansion and compression pipeline) among N_REQ requester channels.
- Locks at message granularity. A grant is held from the first word of a message, through the word carrying the last flag, until the core returns the 256-bit digest.
- Routes the digest back to the owning channel, then re-arbitrates.
- Sits between the per-channel message sources and the SM3 core input/output interface.

Parameters:
- N_REQ, 4, number of requester channels (2..8).
- DATA_W, 32, message word width on both the requester side and the core side.
- RES_W, 256, digest width.
- IDX_W, $clog2(N_REQ), channel index width (derived).

Ports:
- clk  in  1  single clock; all logic rising-edge.
- rst  in  1  reset, synchronous, active-high.
- req_data_i  in  N_REQ*DATA_W  per-channel message word; channel k occupies bits [k*DATA_W +: DATA_W].
- req_vld_i  in  N_REQ  per-channel word valid.
- req_lst_i  in  N_REQ  per-channel last word of message, qualified by vld.
- req_rdy_o  out  N_REQ  per-channel word accepted.
- core_inpt_data_o  out  DATA_W  word to the core.
- core_inpt_vld_o  out  1  word valid to the core.
- core_inpt_lst_o  out  1  last-word flag to the core.
- core_inpt_rdy_i  in  1  core accepts a word.
- core_otpt_res_i  in  RES_W  digest from the core.
- core_otpt_vld_i  in  1  digest valid, single-cycle pulse.
- res_data_o  out  RES_W  registered digest to the requesters.
- res_vld_o  out  N_REQ  one-hot digest valid to the owning channel.
- gnt_o  out  N_REQ  one-hot current owner; all zero when idle.
- err_unexp_o  out  1  one-cycle pulse: digest arrived while not in WAIT_RES.

Behaviour:
- State machine: IDLE, XFER, WAIT_RES. Registered state, registered grant index, registered rr_ptr.
- Reset values:
  - state = IDLE, gnt = 0, rr_ptr = 0.
  - res_vld_o = 0, res_data_o = 0, err_unexp_o = 0.
  - core_inpt_vld_o = 0, req_rdy_o = 0.
- IDLE:
  - If any req_vld_i is set, pick the first set bit at or after rr_ptr, wrapping modulo N_REQ.
  - Register it as the grant and go to XFER on the next edge. Arbitration latency is 1 cycle.
  - No word is accepted in IDLE: req_rdy_o = 0 and core_inpt_vld_o = 0.
- XFER: combinational pass-through for the granted channel g only.
  - core_inpt_data_o = req_data[g]; core_inpt_vld_o = req_vld_i[g]; core_inpt_lst_o = req_lst_i[g].
  - req_rdy_o[g] = core_inpt_rdy_i; all other req_rdy_o bits are 0.
  - Handshake: vld & rdy in the same cycle.
  - A handshake with lst = 1 moves the block to WAIT_RES.
  - Non-granted channels must hold their valid and data; they are never dropped.
- WAIT_RES:
  - core_inpt_vld_o = 0 and all req_rdy_o = 0.
  - On core_otpt_vld_i: on the next edge, set res_data_o = core_otpt_res_i and res_vld_o = onehot(g) for exactly 1 cycle.
  - On that same edge, state goes to IDLE, gnt clears, and rr_ptr = (g+1) mod N_REQ.
  - Result latency: 1 cycle after core_otpt_vld_i.
  - The earliest re-grant is decided in the cycle after the return, so there are no back-to-back grants without an IDLE cycle.
- res_data_o holds its last value until the next digest.
- A digest that arrives in IDLE or XFER is dropped. err_unexp_o pulses 1 cycle later. State is unchanged.
- Single-word messages (lst on the first word) are legal.
- A stalled core (rdy held low) keeps the grant indefinitely. There is no timeout.
- When only one channel is requesting, it is served regardless of rr_ptr.
- rst asserted mid-message returns everything to the reset values on the next edge, and any partial message is abandoned.
  - The core is reset by the same rst, so no stale digest is expected.
  - A digest arriving after reset flags err_unexp_o.

Decomposition:
- Package sm3_arb_pkg:
  - state enum {IDLE, XFER, WAIT_RES}.
  - Default N_REQ, DATA_W and RES_W constants.
  - A function onehot(idx).
- Sub-module sm3_rr_pick: combinational round-robin picker.
  - Inputs: req vector, rr_ptr.
  - Outputs: found, idx.
  - Implemented as a double-width masked priority encode.

Test Plan:
- Single channel 2, 3-word message (0x61626380, 0, 0x18 with lst), core rdy = 1, digest 0x66c7f0f4...8f4ba8e0 returned 5 cycles after lst → gnt_o = 0100 one cycle after req, the 3 words appear on core_inpt in order with lst on word 3, res_vld_o = 0100 for 1 cycle, res_data_o = digest, rr_ptr = 3.
- All 4 channels request continuously with 1-word messages → grant order 0,1,2,3,0; each owns exactly one message; no word crosses channels; each res_vld_o goes to the correct channel.
- Channel 1 mid-message with core_inpt_rdy_i toggling 1,0,0,1 while channel 0 requests → only channel 1 handshakes; channel 0's req_rdy_o stays 0; channel 0 is granted only after channel 1's digest returns.
- core_otpt_vld_i pulsed in IDLE → err_unexp_o = 1 for one cycle; res_vld_o = 0; res_data_o unchanged.
- rst asserted in XFER after 2 of 4 words → next cycle state IDLE, gnt_o = 0, req_rdy_o = 0, rr_ptr = 0; a new request on channel 3 is then granted normally.
- Channel 3 is the only requester with rr_ptr = 0 → granted 1 cycle later; after its return rr_ptr wraps to 0.
